// File: rtl/monobit_blockfreq_core.sv
// Monobit and block-frequency randomness tester over a 2^SEQ_LOG2-bit serial stream.
// Latency: results and a one-cycle done pulse appear two cycles after the final bit is consumed.
// Backpressure: none; the source paces bits with bit_valid, and gaps cost nothing.
module monobit_blockfreq_core #(
  parameter int SEQ_LOG2 = 7,
  parameter int BLK_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  input  logic [SEQ_LOG2:0]            thr_mono,
  input  logic [BLK_LOG2:0]            thr_blk,
  input  logic [SEQ_LOG2-BLK_LOG2:0]   max_bad,
  output logic                         busy,
  output logic                         done,
  output logic                         pass_mono,
  output logic                         pass_blk,
  output logic [SEQ_LOG2:0]            ones_count,
  output logic [SEQ_LOG2:0]            abs_s,
  output logic [SEQ_LOG2-BLK_LOG2:0]   bad_blocks
);

  // N and M carried with one spare bit so that doubled counts never wrap.
  localparam logic [SEQ_LOG2+1:0] N_VAL = {2'b01, {SEQ_LOG2{1'b0}}};
  localparam logic [BLK_LOG2+1:0] M_VAL = {2'b01, {BLK_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2
  } state_t;

  state_t                       state;
  logic [SEQ_LOG2:0]            thr_mono_q;
  logic [BLK_LOG2:0]            thr_blk_q;
  logic [SEQ_LOG2-BLK_LOG2:0]   max_bad_q;
  logic [SEQ_LOG2-1:0]          bit_cnt;
  logic [SEQ_LOG2:0]            ones_cnt;
  logic [BLK_LOG2:0]            blk_ones;
  logic [SEQ_LOG2-BLK_LOG2:0]   bad_cnt;

  logic [BLK_LOG2:0]            blk_ones_nxt;
  logic [BLK_LOG2+1:0]          blk_twice;
  logic [BLK_LOG2+1:0]          blk_dev;
  logic                         blk_bad;
  logic                         blk_close;
  logic                         seq_last;
  logic [SEQ_LOG2+1:0]          ones_twice;
  logic [SEQ_LOG2+1:0]          abs_full;

  // Block deviation (including the bit on the wire) and sequence-wide |S|.
  always_comb begin
    blk_ones_nxt = blk_ones + {{BLK_LOG2{1'b0}}, bit_in};
    blk_twice    = {blk_ones_nxt, 1'b0};
    blk_dev      = (blk_twice >= M_VAL) ? (blk_twice - M_VAL) : (M_VAL - blk_twice);
    blk_bad      = (blk_dev > {1'b0, thr_blk_q});
    blk_close    = &bit_cnt[BLK_LOG2-1:0];
    seq_last     = &bit_cnt;
    ones_twice   = {ones_cnt, 1'b0};
    abs_full     = (ones_twice >= N_VAL) ? (ones_twice - N_VAL) : (N_VAL - ones_twice);
  end

  // Control FSM with counters and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      thr_mono_q <= '0;
      thr_blk_q  <= '0;
      max_bad_q  <= '0;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      blk_ones   <= '0;
      bad_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_mono  <= 1'b0;
      pass_blk   <= 1'b0;
      ones_count <= '0;
      abs_s      <= '0;
      bad_blocks <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A bit presented alongside start is deliberately not consumed.
          if (start) begin
            thr_mono_q <= thr_mono;
            thr_blk_q  <= thr_blk;
            max_bad_q  <= max_bad;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            blk_ones   <= '0;
            bad_cnt    <= '0;
            busy       <= 1'b1;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (bit_valid) begin
            bit_cnt  <= bit_cnt + {{(SEQ_LOG2-1){1'b0}}, 1'b1};
            ones_cnt <= ones_cnt + {{SEQ_LOG2{1'b0}}, bit_in};
            if (blk_close) begin
              blk_ones <= '0;
              bad_cnt  <= bad_cnt + {{(SEQ_LOG2-BLK_LOG2){1'b0}}, blk_bad};
            end else begin
              blk_ones <= blk_ones_nxt;
            end
            // The final bit also closes the last block; bit_cnt wraps to 0 here.
            if (seq_last) begin
              state <= EVAL;
            end
          end
        end
        EVAL: begin
          ones_count <= ones_cnt;
          abs_s      <= abs_full[SEQ_LOG2:0];
          bad_blocks <= bad_cnt;
          pass_mono  <= (abs_full <= {1'b0, thr_mono_q});
          pass_blk   <= (bad_cnt <= max_bad_q);
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
